// File: rtl/t08_decode_queue.sv
// RV32I decode stage: combinational decode of instr into a DEPTH-entry op FIFO; a push reaches the head one cycle later.
// instr_ready drops while full; the head holds until out_ready. Optional M-extension decode is enabled by T08_MEXT_EN.
module t08_decode_queue #(
    parameter int DEPTH     = 2,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 read,
    output logic                 write,
    output logic [2:0]           funct3,
    output logic [1:0]           data_in_control,
    output logic [4:0]           reg1,
    output logic [4:0]           reg2,
    output logic [4:0]           regd,
    output logic                 en_read_1,
    output logic                 en_read_2,
    output logic                 en_write,
    output logic [31:0]          immediate,
    output logic [5:0]           alu_control,
    output logic                 jump,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] illegal_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef struct packed {
        logic        illegal;
        logic        jump;
        logic [5:0]  alu;
        logic [31:0] imm;
        logic        en_w;
        logic        en_r2;
        logic        en_r1;
        logic [4:0]  regd;
        logic [4:0]  reg2;
        logic [4:0]  reg1;
        logic [1:0]  dic;
        logic [2:0]  funct3;
        logic        write;
        logic        read;
    } op_t;

    op_t                 dec;
    op_t                 head;
    op_t                 mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic                push, pop, ok;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec      = '0;
        ok       = 1'b1;
        dec.reg1 = instr[19:15];
        dec.reg2 = instr[24:20];
        dec.regd = instr[11:7];
        case (opcode)
            7'b0110011: begin
                dec.en_r1 = 1'b1;
                dec.en_r2 = 1'b1;
                dec.en_w  = 1'b1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: dec.alu = 6'd1;
                        3'd1: dec.alu = 6'd3;
                        3'd2: dec.alu = 6'd4;
                        3'd3: dec.alu = 6'd5;
                        3'd4: dec.alu = 6'd6;
                        3'd5: dec.alu = 6'd7;
                        3'd6: dec.alu = 6'd9;
                        default: dec.alu = 6'd10;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    dec.alu = 6'd2;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    dec.alu = 6'd8;
`ifdef T08_MEXT_EN
                end else if (f7 == 7'h01) begin
                    dec.alu = 6'd38 + {3'b0, f3};
`endif
                end else begin
                    ok = 1'b0;
                end
            end
            7'b0010011: begin
                dec.en_r1 = 1'b1;
                dec.en_w  = 1'b1;
                dec.imm   = imm_i;
                case (f3)
                    3'd0: dec.alu = 6'd11;
                    3'd1: begin dec.alu = 6'd17; ok = (f7 == 7'h00); end
                    3'd2: dec.alu = 6'd12;
                    3'd3: dec.alu = 6'd13;
                    3'd4: dec.alu = 6'd14;
                    3'd5: begin
                        dec.alu = (f7 == 7'h20) ? 6'd19 : 6'd18;
                        ok      = (f7 == 7'h00) || (f7 == 7'h20);
                    end
                    3'd6: dec.alu = 6'd15;
                    default: dec.alu = 6'd16;
                endcase
            end
            7'b0000011: begin
                dec.en_r1  = 1'b1;
                dec.en_w   = 1'b1;
                dec.read   = 1'b1;
                dec.dic    = 2'd1;
                dec.imm    = imm_i;
                dec.funct3 = f3;
                case (f3)
                    3'd0: dec.alu = 6'd20;
                    3'd1: dec.alu = 6'd21;
                    3'd2: dec.alu = 6'd22;
                    3'd4: dec.alu = 6'd23;
                    3'd5: dec.alu = 6'd24;
                    default: ok = 1'b0;
                endcase
            end
            7'b0100011: begin
                dec.en_r1  = 1'b1;
                dec.en_r2  = 1'b1;
                dec.write  = 1'b1;
                dec.imm    = imm_s;
                dec.funct3 = f3;
                dec.alu    = 6'd25 + {3'b0, f3};
                ok         = (f3 <= 3'd2);
            end
            7'b1100011: begin
                dec.en_r1 = 1'b1;
                dec.en_r2 = 1'b1;
                dec.imm   = imm_b;
                case (f3)
                    3'd0: dec.alu = 6'd28;
                    3'd1: dec.alu = 6'd29;
                    3'd4: dec.alu = 6'd30;
                    3'd5: dec.alu = 6'd31;
                    3'd6: dec.alu = 6'd32;
                    3'd7: dec.alu = 6'd33;
                    default: ok = 1'b0;
                endcase
            end
            7'b0110111: begin dec.alu = 6'd34; dec.en_w = 1'b1; dec.imm = imm_u; dec.dic = 2'd2; end
            7'b0010111: begin dec.alu = 6'd35; dec.en_w = 1'b1; dec.imm = imm_u; end
            7'b1101111: begin
                dec.alu = 6'd36; dec.en_w = 1'b1; dec.imm = imm_j; dec.dic = 2'd3; dec.jump = 1'b1;
            end
            7'b1100111: begin
                dec.alu = 6'd37; dec.en_r1 = 1'b1; dec.en_w = 1'b1; dec.imm = imm_i;
                dec.dic = 2'd3; dec.jump = 1'b1;
            end
            default: ok = 1'b0;
        endcase
        // Illegal ops still travel down the pipe, but must not touch any architectural state.
        if (!ok) begin
            dec.illegal = 1'b1;
            dec.alu     = '0;
            dec.en_r1   = 1'b0;
            dec.en_r2   = 1'b0;
            dec.en_w    = 1'b0;
            dec.read    = 1'b0;
            dec.write   = 1'b0;
            dec.jump    = 1'b0;
            dec.dic     = '0;
        end
        if (dec.regd == 5'd0) dec.en_w = 1'b0;
    end

    assign instr_ready = (count_q < DEPTH_C);
    assign out_valid   = (count_q != '0);
    assign push        = instr_valid && instr_ready && !flush;
    assign pop         = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ill_cnt_d = ill_cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (push && dec.illegal && ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ill_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    assign head            = out_valid ? mem_q[rd_ptr_q] : '0;
    assign read            = head.read;
    assign write           = head.write;
    assign funct3          = head.funct3;
    assign data_in_control = head.dic;
    assign reg1            = head.reg1;
    assign reg2            = head.reg2;
    assign regd            = head.regd;
    assign en_read_1       = head.en_r1;
    assign en_read_2       = head.en_r2;
    assign en_write        = head.en_w;
    assign immediate       = head.imm;
    assign alu_control     = head.alu;
    assign jump            = head.jump;
    assign illegal         = head.illegal;
    assign illegal_count   = ill_cnt_q;
endmodule

// File: tb/tb_t08_decode_queue.sv
// Directed bench for t08_decode_queue: a decode vector table plus hand sequences for backpressure, flush,
// mid-stream reset and illegal-counter saturation.
module tb_t08_decode_queue;
    logic        clk = 1'b0;
    logic        reset, instr_valid, flush, out_ready;
    logic [31:0] instr;
    logic        instr_ready, out_valid, read, write, en_read_1, en_read_2, en_write, jump, illegal;
    logic [2:0]  funct3;
    logic [1:0]  data_in_control;
    logic [4:0]  reg1, reg2, regd;
    logic [31:0] immediate;
    logic [5:0]  alu_control;
    logic [7:0]  illegal_count;

    t08_decode_queue #(.DEPTH(2), .ILL_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .read(read), .write(write),
        .funct3(funct3), .data_in_control(data_in_control), .reg1(reg1), .reg2(reg2), .regd(regd),
        .en_read_1(en_read_1), .en_read_2(en_read_2), .en_write(en_write), .immediate(immediate),
        .alu_control(alu_control), .jump(jump), .illegal(illegal), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    // flags = {read, write, en_read_1, en_read_2, en_write, jump, illegal}
    typedef struct packed {
        logic [31:0] instr;
        logic [5:0]  alu;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [1:0]  dic;
        logic [6:0]  flags;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_ill = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    initial begin
        vecs[0]  = '{32'h002081B3, 6'd1,  32'h00000000, 3'd0, 2'd0, 7'b0011100}; // ADD
        vecs[1]  = '{32'hFFF00293, 6'd11, 32'hFFFFFFFF, 3'd0, 2'd0, 7'b0010100}; // ADDI x5,x0,-1
        vecs[2]  = '{32'h00000013, 6'd11, 32'h00000000, 3'd0, 2'd0, 7'b0010000}; // NOP
        vecs[3]  = '{32'h0020A423, 6'd27, 32'h00000008, 3'd2, 2'd0, 7'b0111000}; // SW x2,8(x1)
        vecs[4]  = '{32'hFFC12203, 6'd22, 32'hFFFFFFFC, 3'd2, 2'd1, 7'b1010100}; // LW x4,-4(x2)
        vecs[5]  = '{32'h123453B7, 6'd34, 32'h12345000, 3'd0, 2'd2, 7'b0000100}; // LUI
        vecs[6]  = '{32'h00001517, 6'd35, 32'h00001000, 3'd0, 2'd0, 7'b0000100}; // AUIPC
        vecs[7]  = '{32'hFFDFF0EF, 6'd36, 32'hFFFFFFFC, 3'd0, 2'd3, 7'b0000110}; // JAL x1,-4
        vecs[8]  = '{32'h00209863, 6'd29, 32'h00000010, 3'd0, 2'd0, 7'b0011000}; // BNE +16
        vecs[9]  = '{32'h4032D293, 6'd19, 32'h00000403, 3'd0, 2'd0, 7'b0010100}; // SRAI
        vecs[10] = '{32'h00008067, 6'd37, 32'h00000000, 3'd0, 2'd3, 7'b0010010}; // JALR x0
        vecs[11] = '{32'h402081B3, 6'd2,  32'h00000000, 3'd0, 2'd0, 7'b0011100}; // SUB
        vecs[12] = '{32'h00013083, 6'd0,  32'h00000000, 3'd0, 2'd0, 7'b0000001}; // load f3=011
        vecs[13] = '{32'h00000000, 6'd0,  32'h00000000, 3'd0, 2'd0, 7'b0000001}; // opcode 0
        vecs[14] = '{32'h40001093, 6'd0,  32'h00000000, 3'd0, 2'd0, 7'b0000001}; // SLLI bad funct7
`ifdef T08_MEXT_EN
        vecs[15] = '{32'h022081B3, 6'd38, 32'h00000000, 3'd0, 2'd0, 7'b0011100}; // MUL
`else
        vecs[15] = '{32'h022081B3, 6'd0,  32'h00000000, 3'd0, 2'd0, 7'b0000001}; // MUL
`endif
        vecs[16] = '{32'h0020A063, 6'd0,  32'h00000000, 3'd0, 2'd0, 7'b0000001}; // branch f3=010

        reset = 1'b1; instr = '0; instr_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_instr_ready", 64'(instr_ready), 64'd1);
        check("rst_ill_cnt", 64'(illegal_count), 64'd0);
        check("rst_bundle_zero", {26'd0, alu_control, immediate}, 64'd0);

        // ADD register fields
        instr = 32'h002081B3; instr_valid = 1'b1;
        @(negedge clk); instr_valid = 1'b0;
        check("add_regs", {48'd0, out_valid, reg1, reg2, regd}, {48'd0, 1'b1, 5'd1, 5'd2, 5'd3});
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        check("add_popped", 64'(out_valid), 64'd0);

        for (int i = 0; i < NV; i++) begin
            instr = vecs[i].instr; instr_valid = 1'b1;
            @(negedge clk); instr_valid = 1'b0;
            check($sformatf("vec%0d_ctl", i),
                  {49'd0, alu_control, read, write, en_read_1, en_read_2, en_write, jump, illegal, out_valid},
                  {49'd0, vecs[i].alu, vecs[i].flags, 1'b1});
            if (!vecs[i].flags[0])
                check($sformatf("vec%0d_data", i), {27'd0, immediate, funct3, data_in_control},
                      {27'd0, vecs[i].imm, vecs[i].f3, vecs[i].dic});
            if (vecs[i].flags[0]) exp_ill = sat_inc(exp_ill);
            check($sformatf("vec%0d_ill_cnt", i), 64'(illegal_count), 64'(exp_ill));
            out_ready = 1'b1;
            @(negedge clk); out_ready = 1'b0;
        end

        // Backpressure: ADD, ADDI, SW with the consumer stalled
        instr = 32'h002081B3; instr_valid = 1'b1;
        @(negedge clk); instr = 32'hFFF00293;
        @(negedge clk);
        check("full_ready", 64'(instr_ready), 64'd0);
        check("full_head", {57'd0, out_valid, alu_control}, {57'd0, 1'b1, 6'd1});
        instr = 32'h0020A423;
        @(negedge clk);
        check("stall_head", {26'd0, alu_control, immediate}, {26'd0, 6'd1, 32'd0});
        check("stall_ready", 64'(instr_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("drain1_head", 64'(alu_control), 64'd11);
        check("drain1_ready", 64'(instr_ready), 64'd1);
        @(negedge clk); instr_valid = 1'b0;
        check("drain2_head", {57'd0, out_valid, alu_control}, {57'd0, 1'b1, 6'd27});
        @(negedge clk); out_ready = 1'b0;
        check("drain_empty", 64'(out_valid), 64'd0);

        // Flush: two queued ops (one illegal), flushed cycle carries another illegal op
        instr = 32'h002081B3; instr_valid = 1'b1;
        @(negedge clk); instr = 32'h00000000;
        @(negedge clk); instr = 32'hFFFFFFFF; flush = 1'b1;
        exp_ill = sat_inc(exp_ill);
        @(negedge clk); flush = 1'b0; instr_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(instr_ready), 64'd1);
        check("flush_ill_cnt", 64'(illegal_count), 64'(exp_ill));
        @(negedge clk);
        check("flush_absent", 64'(out_valid), 64'd0);
        instr = 32'h00000013; instr_valid = 1'b1;
        @(negedge clk); instr_valid = 1'b0;
        check("post_flush_push", {57'd0, out_valid, alu_control}, {57'd0, 1'b1, 6'd11});

        // Reset with an op still queued
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; exp_ill = 0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_ill_cnt", 64'(illegal_count), 64'd0);

        // MUL then saturation of the illegal counter
        instr = 32'h022081B3; instr_valid = 1'b1;
        @(negedge clk); instr_valid = 1'b0;
`ifdef T08_MEXT_EN
        check("mul_decode", {56'd0, illegal, 1'b0, alu_control}, {56'd0, 1'b0, 1'b0, 6'd38});
`else
        check("mul_decode", {56'd0, illegal, 1'b0, alu_control}, {56'd0, 1'b1, 1'b0, 6'd0});
        exp_ill = sat_inc(exp_ill);
`endif
        check("mul_ill_cnt", 64'(illegal_count), 64'(exp_ill));
        out_ready = 1'b1; instr = 32'h00000000; instr_valid = 1'b1;
        begin
            int pushes = 0;
            int guard = 0;
            while (pushes < 255 && guard < 2000) begin
                if (instr_ready) pushes++;
                @(negedge clk);
                guard++;
            end
            instr_valid = 1'b0;
            if (pushes != 255) begin
                n_cmp++; n_bad++;
                $display("FAIL sat_push_budget: got %0d pushes, required 255", pushes);
            end
            for (int k = 0; k < pushes; k++) exp_ill = sat_inc(exp_ill);
        end
        repeat (3) @(negedge clk);
        check("sat_ill_cnt", 64'(illegal_count), 64'(exp_ill));
        check("sat_value", 64'(illegal_count), 64'd255);
        instr = 32'hFFFFFFFF; instr_valid = 1'b1;
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk);
        check("sat_hold", 64'(illegal_count), 64'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
